lockstep_commit_checker: RTL and testbench

//  Synthesizable lockstep checker for the pipelined CPU. Compares retirement streams from the DUT and the reference model

---
 rtl/lockstep_commit_checker.sv | 251 +++++++++++++++++++++++++
 tb/tb_lockstep_commit_checker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_commit_checker.sv
// Lockstep retirement checker: per-channel skew FIFOs for the DUT and the
// reference model, head-to-head compare, watchdogs and a pass/fail verdict.
// Optional build macro: CHECKER_STOP_ON_MISMATCH_EN (first mismatch ends the run).
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_RUN       | normal checking, waiting for HLT on either side
// S_HALT_SKEW | one side halted, waiting for the other within TIMEOUT
// S_DRAIN     | both halted, waiting for all FIFOs to empty
// S_DONE      | drained cleanly (pass still depends on sticky flags)
// S_FAIL      | overflow / timeout / stop-on-mismatch, absorbing
module lockstep_commit_checker #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int EW     = TAG_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        dut_valid,
    input  logic [NUM_CH*TAG_W-1:0]  dut_tag,
    input  logic [NUM_CH*DATA_W-1:0] dut_data,
    input  logic [NUM_CH-1:0]        ref_valid,
    input  logic [NUM_CH*TAG_W-1:0]  ref_tag,
    input  logic [NUM_CH*DATA_W-1:0] ref_data,
    input  logic                     dut_hlt,
    input  logic                     ref_hlt,
    output logic                     mismatch,
    output logic [CH_W-1:0]          mm_ch,
    output logic [EW-1:0]            mm_dut,
    output logic [EW-1:0]            mm_ref,
    output logic [15:0]              err_count,
    output logic [31:0]              match_count,
    output logic [NUM_CH-1:0]        overflow,
    output logic                     timeout,
    output logic                     done,
    output logic                     pass
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int WDW   = $clog2(TIMEOUT + 1);
    localparam int CNT_W = CH_W + 1;

`ifdef CHECKER_STOP_ON_MISMATCH_EN
    localparam bit STOP_ON_MM = 1'b1;
`else
    localparam bit STOP_ON_MM = 1'b0;
`endif

    typedef enum logic [2:0] {S_RUN, S_HALT_SKEW, S_DRAIN, S_DONE, S_FAIL} state_t;

    state_t           r_state;
    logic [WDW-1:0]   r_wdog;
    logic [WDW-1:0]   r_hcnt;
    logic             r_timeout;
    logic             r_mismatch;
    logic [CH_W-1:0]  r_mm_ch;
    logic [EW-1:0]    r_mm_dut;
    logic [EW-1:0]    r_mm_ref;
    logic [15:0]      r_err;
    logic [31:0]      r_match;
    logic [NUM_CH-1:0] r_overflow;

    logic [EW-1:0]    r_dmem [NUM_CH][DEPTH];
    logic [EW-1:0]    r_rmem [NUM_CH][DEPTH];
    logic [PW-1:0]    r_dwp [NUM_CH];
    logic [PW-1:0]    r_drp [NUM_CH];
    logic [PW-1:0]    r_rwp [NUM_CH];
    logic [PW-1:0]    r_rrp [NUM_CH];

    logic             w_active;
    logic             w_pop_en;
    logic [NUM_CH-1:0] w_d_empty, w_r_empty, w_d_full, w_r_full;
    logic [NUM_CH-1:0] w_pop, w_d_push, w_r_push, w_d_drop, w_r_drop;
    logic [NUM_CH-1:0] w_eq, w_neq;
    logic [EW-1:0]    w_dhead [NUM_CH];
    logic [EW-1:0]    w_rhead [NUM_CH];
    logic [CNT_W-1:0] w_n_eq, w_n_neq;
    logic [CH_W-1:0]  w_first_ch;
    logic [EW-1:0]    w_first_dut, w_first_ref;
    logic             w_skew, w_all_empty;
    logic [16:0]      w_err_sum;
    logic [32:0]      w_match_sum;

    // FIFO status, pop/push decisions and per-channel compare results
    always_comb begin
        w_active    = (r_state == S_RUN) || (r_state == S_HALT_SKEW) || (r_state == S_DRAIN);
        w_pop_en    = w_active && !(STOP_ON_MM && r_mismatch);
        w_d_empty   = '0;
        w_r_empty   = '0;
        w_d_full    = '0;
        w_r_full    = '0;
        w_pop       = '0;
        w_d_push    = '0;
        w_r_push    = '0;
        w_d_drop    = '0;
        w_r_drop    = '0;
        w_eq        = '0;
        w_neq       = '0;
        w_n_eq      = '0;
        w_n_neq     = '0;
        w_first_ch  = '0;
        w_first_dut = '0;
        w_first_ref = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_dhead[c]   = r_dmem[c][r_drp[c][AW-1:0]];
            w_rhead[c]   = r_rmem[c][r_rrp[c][AW-1:0]];
            w_d_empty[c] = (r_dwp[c] == r_drp[c]);
            w_r_empty[c] = (r_rwp[c] == r_rrp[c]);
            w_d_full[c]  = (r_dwp[c][AW] != r_drp[c][AW]) && (r_dwp[c][AW-1:0] == r_drp[c][AW-1:0]);
            w_r_full[c]  = (r_rwp[c][AW] != r_rrp[c][AW]) && (r_rwp[c][AW-1:0] == r_rrp[c][AW-1:0]);
            w_pop[c]     = w_pop_en && !w_d_empty[c] && !w_r_empty[c];
            // a full FIFO still accepts a push when its head leaves this cycle
            w_d_push[c]  = w_active && dut_valid[c] && (!w_d_full[c] || w_pop[c]);
            w_r_push[c]  = w_active && ref_valid[c] && (!w_r_full[c] || w_pop[c]);
            w_d_drop[c]  = w_active && dut_valid[c] && w_d_full[c] && !w_pop[c];
            w_r_drop[c]  = w_active && ref_valid[c] && w_r_full[c] && !w_pop[c];
            w_eq[c]      = w_pop[c] && (w_dhead[c] == w_rhead[c]);
            w_neq[c]     = w_pop[c] && (w_dhead[c] != w_rhead[c]);
            w_n_eq       = w_n_eq + CNT_W'(w_eq[c]);
            w_n_neq      = w_n_neq + CNT_W'(w_neq[c]);
        end
        // walk downwards so the lowest mismatching channel wins
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_neq[c]) begin
                w_first_ch  = CH_W'(c);
                w_first_dut = w_dhead[c];
                w_first_ref = w_rhead[c];
            end
        end
        w_skew      = |(w_d_empty ^ w_r_empty);
        w_all_empty = &(w_d_empty & w_r_empty);
        w_err_sum   = {1'b0, r_err} + 17'(w_n_neq);
        w_match_sum = {1'b0, r_match} + 33'(w_n_eq);
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_d_push[c])
                r_dmem[c][r_dwp[c][AW-1:0]] <= {dut_tag[c*TAG_W +: TAG_W], dut_data[c*DATA_W +: DATA_W]};
            if (w_r_push[c])
                r_rmem[c][r_rwp[c][AW-1:0]] <= {ref_tag[c*TAG_W +: TAG_W], ref_data[c*DATA_W +: DATA_W]};
        end
    end

    // FIFO pointers; reset empties every queue
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst_n) begin
                r_dwp[c] <= '0;
                r_drp[c] <= '0;
                r_rwp[c] <= '0;
                r_rrp[c] <= '0;
            end else begin
                if (w_d_push[c]) r_dwp[c] <= r_dwp[c] + PW'(1);
                if (w_r_push[c]) r_rwp[c] <= r_rwp[c] + PW'(1);
                if (w_pop[c]) begin
                    r_drp[c] <= r_drp[c] + PW'(1);
                    r_rrp[c] <= r_rrp[c] + PW'(1);
                end
            end
        end
    end

    // Registered compare results: sticky first-mismatch capture, saturating counters, overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mismatch <= 1'b0;
            r_mm_ch    <= '0;
            r_mm_dut   <= '0;
            r_mm_ref   <= '0;
            r_err      <= '0;
            r_match    <= '0;
            r_overflow <= '0;
        end else begin
            if (|w_neq) begin
                r_mismatch <= 1'b1;
                if (!r_mismatch) begin
                    r_mm_ch  <= w_first_ch;
                    r_mm_dut <= w_first_dut;
                    r_mm_ref <= w_first_ref;
                end
            end
            r_err      <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
            r_match    <= w_match_sum[32] ? 32'hFFFF_FFFF : w_match_sum[31:0];
            r_overflow <= r_overflow | w_d_drop | w_r_drop;
        end
    end

    // Sequencing FSM with skew watchdog and halt-skew counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_wdog    <= '0;
            r_hcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_active) begin
                if ((|w_pop) || !w_skew) begin
                    r_wdog <= '0;
                end else if (r_wdog != WDW'(TIMEOUT)) begin
                    r_wdog <= r_wdog + WDW'(1);
                    if (r_wdog == WDW'(TIMEOUT - 1)) r_timeout <= 1'b1;
                end
            end
            case (r_state)
                S_RUN, S_HALT_SKEW, S_DRAIN: begin
                    if (r_timeout || (|r_overflow) || (STOP_ON_MM && r_mismatch)) begin
                        r_state <= S_FAIL;
                    end else if (r_state == S_RUN) begin
                        if (dut_hlt && ref_hlt) begin
                            r_state <= S_DRAIN;
                        end else if (dut_hlt != ref_hlt) begin
                            r_state <= S_HALT_SKEW;
                            r_hcnt  <= '0;
                        end
                    end else if (r_state == S_HALT_SKEW) begin
                        if (dut_hlt && ref_hlt) begin
                            r_state <= S_DRAIN;
                        end else if (r_hcnt == WDW'(TIMEOUT - 1)) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_FAIL;
                        end else begin
                            r_hcnt <= r_hcnt + WDW'(1);
                        end
                    end else if (w_all_empty) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign mismatch    = r_mismatch;
    assign mm_ch       = r_mm_ch;
    assign mm_dut      = r_mm_dut;
    assign mm_ref      = r_mm_ref;
    assign err_count   = r_err;
    assign match_count = r_match;
    assign overflow    = r_overflow;
    assign timeout     = r_timeout;
    assign done        = (r_state == S_DONE) || (r_state == S_FAIL);
    assign pass        = done && !r_mismatch && !(|r_overflow) && !r_timeout;

endmodule

// File: tb/tb_lockstep_commit_checker.sv
// Bench for lockstep_commit_checker: directed scenarios plus randomized
// skewed retirement streams, checked every cycle against a queue-based model.
module tb_lockstep_commit_checker;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int EW      = TAG_W + DATA_W;

`ifdef CHECKER_STOP_ON_MISMATCH_EN
    localparam bit STOP_MM = 1'b1;
`else
    localparam bit STOP_MM = 1'b0;
`endif

    localparam int M_RUN = 0, M_SKEW = 1, M_DRAIN = 2, M_DONE = 3, M_FAIL = 4;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        dut_valid, ref_valid;
    logic [NUM_CH*TAG_W-1:0]  dut_tag, ref_tag;
    logic [NUM_CH*DATA_W-1:0] dut_data, ref_data;
    logic                     dut_hlt, ref_hlt;
    logic                     mismatch;
    logic                     mm_ch;
    logic [EW-1:0]            mm_dut, mm_ref;
    logic [15:0]              err_count;
    logic [31:0]              match_count;
    logic [NUM_CH-1:0]        overflow;
    logic                     timeout, done, pass;

    lockstep_commit_checker #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dut_valid(dut_valid), .dut_tag(dut_tag), .dut_data(dut_data),
        .ref_valid(ref_valid), .ref_tag(ref_tag), .ref_data(ref_data),
        .dut_hlt(dut_hlt), .ref_hlt(ref_hlt),
        .mismatch(mismatch), .mm_ch(mm_ch), .mm_dut(mm_dut), .mm_ref(mm_ref),
        .err_count(err_count), .match_count(match_count), .overflow(overflow),
        .timeout(timeout), .done(done), .pass(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    logic [EW-1:0]     mdq [NUM_CH][$];
    logic [EW-1:0]     mrq [NUM_CH][$];
    logic [EW-1:0]     pend [NUM_CH][$];
    int                m_st;
    int                m_wdog, m_hcnt;
    bit                m_timeout, m_mismatch;
    int                m_mm_ch;
    logic [EW-1:0]     m_mm_dut, m_mm_ref;
    longint            m_err, m_match;
    logic [NUM_CH-1:0] m_ovf;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            mdq[c].delete();
            mrq[c].delete();
        end
        m_st = M_RUN; m_wdog = 0; m_hcnt = 0; m_timeout = 0; m_mismatch = 0;
        m_mm_ch = 0; m_mm_dut = '0; m_mm_ref = '0; m_err = 0; m_match = 0; m_ovf = '0;
    endtask

    // one clock edge of the checker, in terms of queues and the documented rules
    task automatic model_step();
        int dsz [NUM_CH];
        int rsz [NUM_CH];
        bit pop [NUM_CH];
        bit act, popen, skew, allemp, flag, anypop, capt;
        int nm, neq;
        logic [EW-1:0] d, r;
        if (!rst_n) begin
            model_clear();
            return;
        end
        act    = (m_st == M_RUN) || (m_st == M_SKEW) || (m_st == M_DRAIN);
        popen  = act && !(STOP_MM && m_mismatch);
        flag   = m_timeout || (m_ovf != 0) || (STOP_MM && m_mismatch);
        skew   = 0; allemp = 1; anypop = 0; capt = 0; nm = 0; neq = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            dsz[c] = mdq[c].size();
            rsz[c] = mrq[c].size();
            if ((dsz[c] == 0) != (rsz[c] == 0)) skew = 1;
            if (dsz[c] != 0 || rsz[c] != 0) allemp = 0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c] = popen && dsz[c] > 0 && rsz[c] > 0;
            if (pop[c]) begin
                anypop = 1;
                d = mdq[c].pop_front();
                r = mrq[c].pop_front();
                if (d == r) neq++;
                else begin
                    nm++;
                    if (!m_mismatch && !capt) begin
                        capt = 1; m_mm_ch = c; m_mm_dut = d; m_mm_ref = r;
                    end
                end
            end
            if (act && dut_valid[c]) begin
                if (dsz[c] == DEPTH && !pop[c]) m_ovf[c] = 1'b1;
                else mdq[c].push_back({dut_tag[c*TAG_W +: TAG_W], dut_data[c*DATA_W +: DATA_W]});
            end
            if (act && ref_valid[c]) begin
                if (rsz[c] == DEPTH && !pop[c]) m_ovf[c] = 1'b1;
                else mrq[c].push_back({ref_tag[c*TAG_W +: TAG_W], ref_data[c*DATA_W +: DATA_W]});
            end
        end
        if (nm > 0) m_mismatch = 1;
        m_err   = (m_err + nm > 65535) ? 65535 : m_err + nm;
        m_match = (m_match + neq > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_match + neq;
        if (act) begin
            if (anypop || !skew) m_wdog = 0;
            else if (m_wdog != TIMEOUT) begin
                m_wdog++;
                if (m_wdog == TIMEOUT) m_timeout = 1;
            end
        end
        if (act && flag) m_st = M_FAIL;
        else if (m_st == M_RUN) begin
            if (dut_hlt && ref_hlt) m_st = M_DRAIN;
            else if (dut_hlt != ref_hlt) begin m_st = M_SKEW; m_hcnt = 0; end
        end else if (m_st == M_SKEW) begin
            if (dut_hlt && ref_hlt) m_st = M_DRAIN;
            else if (m_hcnt + 1 == TIMEOUT) begin m_timeout = 1; m_st = M_FAIL; end
            else m_hcnt++;
        end else if (m_st == M_DRAIN) begin
            if (allemp) m_st = M_DONE;
        end
    endtask

    task automatic check_all();
        bit e_done;
        e_done = (m_st == M_DONE) || (m_st == M_FAIL);
        check_eq("mismatch", 64'(mismatch), 64'(m_mismatch));
        check_eq("mm_ch", 64'(mm_ch), 64'(m_mm_ch));
        check_eq("mm_dut", 64'(mm_dut), 64'(m_mm_dut));
        check_eq("mm_ref", 64'(mm_ref), 64'(m_mm_ref));
        check_eq("err_count", 64'(err_count), 64'(m_err));
        check_eq("match_count", 64'(match_count), 64'(m_match));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("timeout", 64'(timeout), 64'(m_timeout));
        check_eq("done", 64'(done), 64'(e_done));
        check_eq("pass", 64'(pass), 64'(e_done && !m_mismatch && m_ovf == 0 && !m_timeout));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        dut_valid = '0;
        ref_valid = '0;
    endtask

    task automatic push_dut(input int c, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        dut_valid[c] = 1'b1;
        dut_tag[c*TAG_W +: TAG_W] = t;
        dut_data[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_ref(input int c, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        ref_valid[c] = 1'b1;
        ref_tag[c*TAG_W +: TAG_W] = t;
        ref_data[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dut_hlt = 1'b0; ref_hlt = 1'b0;
        dut_valid = '0; ref_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [EW-1:0] e;
        int lag;
        dut_tag = '0; dut_data = '0; ref_tag = '0; ref_data = '0;
        model_clear();
        do_reset();
        check_eq("rst_match", 64'(match_count), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);

        // matched pair on ch0
        push_dut(0, 4'd3, 16'h1234); push_ref(0, 4'd3, 16'h1234);
        tick();
        tick();
        check_eq("t1_match", 64'(match_count), 64'd1);
        check_eq("t1_mm", 64'(mismatch), 64'd0);

        // DUT leads the model by five cycles
        for (int i = 0; i < 9; i++) begin
            if (i < 4) push_dut(0, 4'(i), 16'hA000 + 16'(i));
            if (i >= 5) push_ref(0, 4'(i - 5), 16'hA000 + 16'(i - 5));
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        check_eq("t2_match", 64'(match_count), 64'd5);
        check_eq("t2_timeout", 64'(timeout), 64'd0);

        // data mismatch on ch1
        push_dut(1, 4'd2, 16'hBEEF); push_ref(1, 4'd2, 16'hBEEE);
        tick();
        tick();
        check_eq("t3_mm", 64'(mismatch), 64'd1);
        check_eq("t3_ch", 64'(mm_ch), 64'd1);
        check_eq("t3_err", 64'(err_count), 64'd1);
        check_eq("t3_dut", 64'(mm_dut), 64'h2BEEF);
        check_eq("t3_ref", 64'(mm_ref), 64'h2BEEE);
        tick();
        tick();
        check_eq("t3_done", 64'(done), 64'(STOP_MM));
        check_eq("t3_pass", 64'(pass), 64'd0);

        // DEPTH+1 DUT pushes with the model idle
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            push_dut(0, 4'(i), 16'(i * 7));
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        check_eq("t4_ovf", 64'(overflow), 64'd1);
        check_eq("t4_done", 64'(done), 64'd1);
        check_eq("t4_pass", 64'(pass), 64'd0);

        // halt skew
        do_reset();
        dut_hlt = 1'b1;
        for (int i = 0; i < TIMEOUT + 4; i++) tick();
        check_eq("t5_timeout", 64'(timeout), 64'd1);
        check_eq("t5_done", 64'(done), 64'd1);
        check_eq("t5_pass", 64'(pass), 64'd0);

        // clean stream, halt, drain
        do_reset();
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e = EW'($urandom);
                push_dut(c, e[EW-1 -: TAG_W], e[DATA_W-1:0]);
                push_ref(c, e[EW-1 -: TAG_W], e[DATA_W-1:0]);
            end
            tick();
        end
        dut_hlt = 1'b1; ref_hlt = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("t6_match", 64'(match_count), 64'd12);
        check_eq("t6_done", 64'(done), 64'd1);
        check_eq("t6_pass", 64'(pass), 64'd1);

        // reset while entries are queued on both sides
        do_reset();
        push_dut(0, 4'd1, 16'h1111); push_ref(0, 4'd1, 16'h1111);
        push_dut(1, 4'd5, 16'h5555);
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("t7_rst_match", 64'(match_count), 64'd0);
        check_eq("t7_rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("t7_discard", 64'(match_count), 64'd0);

        // randomized skewed streams, later runs with occasional corruption
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int c = 0; c < NUM_CH; c++) pend[c].delete();
            lag = $urandom_range(0, 6);
            for (int cyc = 0; cyc < 260; cyc++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (cyc < 200 && $urandom_range(0, 99) < 40) begin
                        e = {4'($urandom), 16'($urandom_range(0, 15))};
                        push_dut(c, e[EW-1 -: TAG_W], e[DATA_W-1:0]);
                        pend[c].push_back(e);
                    end
                    if (pend[c].size() > 0 && $urandom_range(0, 99) < 55) begin
                        e = pend[c].pop_front();
                        if (run >= 2 && $urandom_range(0, 99) < 3) e[0] = ~e[0];
                        push_ref(c, e[EW-1 -: TAG_W], e[DATA_W-1:0]);
                    end
                end
                dut_hlt = (cyc >= 200);
                ref_hlt = (cyc >= 200 + lag);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
